// File: rtl/lock_supervisor_if.sv
// Signal bundle between the button front-end/lock FSM side and the lock supervisor.
// The supervisor uses the slave view; the surrounding logic uses the master view.
interface lock_supervisor_if;
  logic [3:0] btn_pulse;
  logic       fsm_unlocked;
  logic       fsm_fail;
  logic [3:0] fsm_btn;
  logic       fsm_clear;
  logic [1:0] fail_cnt;
  logic       lockout;
  logic [2:0] rgb;

  modport slave (
    input  btn_pulse, fsm_unlocked, fsm_fail,
    output fsm_btn, fsm_clear, fail_cnt, lockout, rgb
  );

  modport master (
    output btn_pulse, fsm_unlocked, fsm_fail,
    input  fsm_btn, fsm_clear, fail_cnt, lockout, rgb
  );
endinterface

// File: rtl/lock_supervisor.sv
// Supervises a combination-lock FSM: filters and forwards presses, counts failed
// attempts, and enforces a timed lockout after too many failures.
module lock_supervisor #(
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned LOCKOUT_SEC = 5,
  parameter int unsigned MAX_FAILS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  lock_supervisor_if.slave bus
);

  // 64-bit product: the legal parameter range can exceed 32 bits.
  localparam logic [63:0] LOCK_CYCLES = 64'(CLK_FREQ) * 64'(LOCKOUT_SEC);
  localparam int TIMER_W = ($clog2(LOCK_CYCLES) < 1) ? 1 : $clog2(LOCK_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCK_CYCLES - 64'd1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(64'd1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(64'd0);
  localparam logic [1:0] MAX_CNT = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKOUT  = 2'b10
  } state_e;

  localparam logic [2:0] RGB_ARMED    = 3'b001;
  localparam logic [2:0] RGB_UNLOCKED = 3'b010;
  localparam logic [2:0] RGB_LOCKOUT  = 3'b100;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [1:0]         fail_cnt_q;
  logic [3:0]         fsm_btn_q;
  logic               fsm_clear_q;
  logic               lockout_q;
  logic [2:0]         rgb_q;

  logic [3:0] btn_fwd_d;
  logic [1:0] fail_inc_d;
  logic       fail_limit_d;

  // Press filter and saturating failure increment
  always_comb begin
    btn_fwd_d    = 4'b0000;
    fail_inc_d   = fail_cnt_q;
    fail_limit_d = 1'b0;
    if ((state_q != ST_LOCKOUT) && is_onehot4(bus.btn_pulse)) begin
      btn_fwd_d = bus.btn_pulse;
    end else begin
      btn_fwd_d = 4'b0000;
    end
    if (fail_cnt_q >= MAX_CNT) begin
      fail_inc_d = MAX_CNT;
    end else begin
      fail_inc_d = fail_cnt_q + 2'd1;
    end
    fail_limit_d = (fail_inc_d >= MAX_CNT);
  end

  // Supervisor state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARMED;
      timer_q     <= TIMER_ZERO;
      fail_cnt_q  <= 2'd0;
      fsm_btn_q   <= 4'b0000;
      fsm_clear_q <= 1'b1;
      lockout_q   <= 1'b0;
      rgb_q       <= RGB_ARMED;
    end else begin
      fsm_btn_q   <= btn_fwd_d;
      fsm_clear_q <= 1'b0;
      case (state_q)
        ST_ARMED: begin
          // A successful unlock outranks a simultaneous failure.
          if (bus.fsm_unlocked) begin
            state_q    <= ST_UNLOCKED;
            fail_cnt_q <= 2'd0;
            lockout_q  <= 1'b0;
            rgb_q      <= RGB_UNLOCKED;
          end else if (bus.fsm_fail) begin
            fail_cnt_q <= fail_inc_d;
            if (fail_limit_d) begin
              state_q     <= ST_LOCKOUT;
              timer_q     <= TIMER_LOAD;
              fsm_clear_q <= 1'b1;
              lockout_q   <= 1'b1;
              rgb_q       <= RGB_LOCKOUT;
            end else begin
              lockout_q <= 1'b0;
              rgb_q     <= RGB_ARMED;
            end
          end else begin
            lockout_q <= 1'b0;
            rgb_q     <= RGB_ARMED;
          end
        end
        ST_UNLOCKED: begin
          if (!bus.fsm_unlocked) begin
            state_q <= ST_ARMED;
            rgb_q   <= RGB_ARMED;
          end else begin
            rgb_q <= RGB_UNLOCKED;
          end
          lockout_q <= 1'b0;
        end
        ST_LOCKOUT: begin
          if (timer_q == TIMER_ZERO) begin
            state_q    <= ST_ARMED;
            fail_cnt_q <= 2'd0;
            lockout_q  <= 1'b0;
            rgb_q      <= RGB_ARMED;
          end else begin
            timer_q   <= timer_q - TIMER_ONE;
            lockout_q <= 1'b1;
            rgb_q     <= RGB_LOCKOUT;
          end
        end
        default: begin
          state_q    <= ST_ARMED;
          timer_q    <= TIMER_ZERO;
          fail_cnt_q <= 2'd0;
          lockout_q  <= 1'b0;
          rgb_q      <= RGB_ARMED;
        end
      endcase
    end
  end

  assign bus.fsm_btn   = fsm_btn_q;
  assign bus.fsm_clear = fsm_clear_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.lockout   = lockout_q;
  assign bus.rgb       = rgb_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench: the driver queues hand-computed expected outputs per cycle and
// an independent monitor pops and compares them after each rising edge.
module tb_lock_supervisor;

  logic clk;
  logic rst;

  lock_supervisor_if bus ();

  lock_supervisor #(
    .CLK_FREQ   (4),
    .LOCKOUT_SEC(1),
    .MAX_FAILS  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         id;
    logic [3:0] btn;
    logic       clr;
    logic [1:0] cnt;
    logic       lock;
    logic [2:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %b expected %b", id, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic [3:0] b, input logic u, input logic f,
                     input logic [3:0] eb, input logic ec, input logic [1:0] en,
                     input logic el, input logic [2:0] eg);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.btn_pulse    = b;
    bus.fsm_unlocked = u;
    bus.fsm_fail     = f;
    step_no++;
    e.id   = step_no;
    e.btn  = eb;
    e.clr  = ec;
    e.cnt  = en;
    e.lock = el;
    e.rgb  = eg;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check("fsm_btn",   cur.id, bus.fsm_btn,           cur.btn);
      check("fsm_clear", cur.id, {3'b000, bus.fsm_clear}, {3'b000, cur.clr});
      check("fail_cnt",  cur.id, {2'b00, bus.fail_cnt},   {2'b00, cur.cnt});
      check("lockout",   cur.id, {3'b000, bus.lockout},   {3'b000, cur.lock});
      check("rgb",       cur.id, {1'b0, bus.rgb},         {1'b0, cur.rgb});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst              = 1'b1;
    bus.btn_pulse    = 4'b0000;
    bus.fsm_unlocked = 1'b0;
    bus.fsm_fail     = 1'b0;

    //   rst  btn      u     f     | exp btn  clr   cnt   lock  rgb
    cyc(1'b1, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b1, 2'd0, 1'b0, 3'b001); // reset
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0100, 1'b0, 1'b0,  4'b0100, 1'b0, 2'd0, 1'b0, 3'b001); // forward S
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0011, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001); // multi-bit dropped
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd1, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd2, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b1, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b010); // unlock clears count
    cyc(1'b0, 4'b0001, 1'b1, 1'b1,  4'b0001, 1'b0, 2'd0, 1'b0, 3'b010); // fail ignored unlocked
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001); // relock
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd1, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd2, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b1, 2'd3, 1'b1, 3'b100); // lockout entry
    cyc(1'b0, 4'b1000, 1'b1, 1'b1,  4'b0000, 1'b0, 2'd3, 1'b1, 3'b100); // all inputs ignored
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd3, 1'b1, 3'b100);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd3, 1'b1, 3'b100);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001); // lockout over after 4
    cyc(1'b0, 4'b1000, 1'b0, 1'b0,  4'b1000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd1, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b1, 1'b1,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b010); // unlock beats fail
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd1, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd2, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b1, 2'd3, 1'b1, 3'b100);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd3, 1'b1, 3'b100); // lockout cycle 2
    cyc(1'b1, 4'b0100, 1'b1, 1'b1,  4'b0000, 1'b1, 2'd0, 1'b0, 3'b001); // reset overrides
    cyc(1'b0, 4'b0000, 1'b0, 1'b0,  4'b0000, 1'b0, 2'd0, 1'b0, 3'b001);
    cyc(1'b0, 4'b0000, 1'b0, 1'b1,  4'b0000, 1'b0, 2'd1, 1'b0, 3'b001);

    @(negedge clk);
    bus.btn_pulse    = 4'b0000;
    bus.fsm_unlocked = 1'b0;
    bus.fsm_fail     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
